// File: rtl/div_rem_sequencer.sv
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring shift-subtract on operand magnitudes, with a one-edge fast path for divide-by-zero and signed overflow.
module div_rem_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [1:0]  DIV_OP,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [4:0]  count, count_next;
    logic [31:0] rem, rem_next;
    logic [31:0] quot, quot_next;
    logic [31:0] dmag, dmag_next;
    logic [1:0]  op, op_next;
    logic        s1, s1_next;
    logic        s2, s2_next;
    logic        done_next;
    logic [31:0] result_next;

    logic        is_signed;
    logic        sign1, sign2;
    logic [31:0] mag1, mag2;
    logic        divisor_zero, overflow;
    logic [32:0] rem_shift;
    logic        no_borrow;
    logic [31:0] diff;

    assign is_signed    = ~DIV_OP[0];
    assign sign1        = DATA1[31] & is_signed;
    assign sign2        = DATA2[31] & is_signed;
    assign mag1         = sign1 ? (~DATA1 + 32'd1) : DATA1;
    assign mag2         = sign2 ? (~DATA2 + 32'd1) : DATA2;
    assign divisor_zero = (DATA2 == 32'd0);
    assign overflow     = is_signed && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);

    // The 33rd remainder bit only exists transiently in the shifted trial value;
    // a kept remainder is always below the divisor magnitude and fits in 32 bits.
    assign rem_shift = {rem, quot[31]};
    assign no_borrow = (rem_shift >= {1'b0, dmag});
    assign diff      = rem_shift[31:0] - dmag;

    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            count  <= 5'd0;
            rem    <= 32'd0;
            quot   <= 32'd0;
            dmag   <= 32'd0;
            op     <= 2'd0;
            s1     <= 1'b0;
            s2     <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= 32'd0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            rem    <= rem_next;
            quot   <= quot_next;
            dmag   <= dmag_next;
            op     <= op_next;
            s1     <= s1_next;
            s2     <= s2_next;
            DONE   <= done_next;
            RESULT <= result_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        rem_next    = rem;
        quot_next   = quot;
        dmag_next   = dmag;
        op_next     = op;
        s1_next     = s1;
        s2_next     = s2;
        done_next   = 1'b0;
        result_next = RESULT;

        unique case (state)
            IDLE: begin
                if (START) begin
                    if (divisor_zero) begin
                        result_next = DIV_OP[1] ? DATA1 : 32'hFFFF_FFFF;
                        done_next   = 1'b1;
                    end else if (overflow) begin
                        result_next = DIV_OP[1] ? 32'd0 : 32'h8000_0000;
                        done_next   = 1'b1;
                    end else begin
                        state_next = ITER;
                        op_next    = DIV_OP;
                        s1_next    = sign1;
                        s2_next    = sign2;
                        quot_next  = mag1;
                        dmag_next  = mag2;
                        rem_next   = 32'd0;
                        count_next = 5'd0;
                    end
                end
            end
            ITER: begin
                if (no_borrow) begin
                    rem_next  = diff;
                    quot_next = {quot[30:0], 1'b1};
                end else begin
                    rem_next  = rem_shift[31:0];
                    quot_next = {quot[30:0], 1'b0};
                end
                count_next = count + 5'd1;
                if (count == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                unique case (op)
                    2'b00:   result_next = (s1 ^ s2) ? (~quot + 32'd1) : quot;
                    2'b01:   result_next = quot;
                    2'b10:   result_next = s1 ? (~rem + 32'd1) : rem;
                    default: result_next = rem;
                endcase
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_rem_sequencer.sv
// Self-checking bench for div_rem_sequencer: directed corner cases plus random
// operations compared against an arithmetic RV32M reference model.
module tb_div_rem_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [1:0]  DIV_OP;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int tests_run    = 0;
    int tests_failed = 0;

    div_rem_sequencer dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .DIV_OP (DIV_OP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // RISC-V semantics: truncating division, remainder takes the dividend's sign.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   ref_result = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            2'b01:   ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   ref_result = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: ref_result = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit ref_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        ref_fast = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Called just after a falling edge; returns after the falling edge where DONE is seen.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int edges, output logic busy_seen);
        DIV_OP = op;
        DATA1  = a;
        DATA2  = b;
        START  = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        edges     = 0;
        busy_seen = 1'b0;
        @(negedge CLK);
        while (!DONE && edges < 40) begin
            busy_seen |= BUSY;
            @(posedge CLK);
            edges++;
            @(negedge CLK);
        end
        res = RESULT;
    endtask

    task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        int          edges;
        logic        busy_seen;
        bit          fast;
        fast = ref_fast(op, a, b);
        applyStimulus(op, a, b, res, edges, busy_seen);
        checkOutput({tag, " result"}, res, ref_result(op, a, b));
        checkOutput({tag, " latency"}, edges, fast ? 0 : 33);
        checkOutput({tag, " busy"}, busy_seen, fast ? 0 : 1);
    endtask

    task automatic check_tail(input string tag, input logic [31:0] held);
        @(negedge CLK);
        checkOutput({tag, " done width"}, DONE, 0);
        checkOutput({tag, " result held"}, RESULT, held);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] a, b;
        logic [1:0]  op;
        int          edges, dones, first_done;
        logic        busy_seen;

        RESET  = 1'b1;
        START  = 1'b0;
        DIV_OP = 2'b00;
        DATA1  = 32'd0;
        DATA2  = 32'd0;
        #12;
        checkOutput("reset busy", BUSY, 0);
        checkOutput("reset done", DONE, 0);
        checkOutput("reset result", RESULT, 0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        run_check("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div -7/2 value", RESULT, 32'hFFFF_FFFD);
        check_tail("div -7/2", 32'hFFFF_FFFD);
        run_check("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        checkOutput("rem -7/2 value", RESULT, 32'hFFFF_FFFF);
        run_check("divu", 2'b01, 32'hFFFF_FFF9, 32'd2);
        checkOutput("divu value", RESULT, 32'h7FFF_FFFC);
        run_check("div by zero", 2'b00, 32'd5, 32'd0);
        check_tail("div by zero", 32'hFFFF_FFFF);
        run_check("remu by zero", 2'b11, 32'h1234, 32'd0);
        checkOutput("remu by zero value", RESULT, 32'h1234);
        run_check("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_check("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_check("divu ovf ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("divu ovf ops value", RESULT, 32'd0);

        // START while busy must be ignored
        DIV_OP = 2'b01; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        edges = 0; dones = 0; first_done = -1; res = 32'd0;
        for (int i = 0; i < 45; i++) begin
            @(negedge CLK);
            if (DONE) begin
                dones++;
                if (first_done < 0) begin
                    first_done = edges;
                    res = RESULT;
                end
            end
            if (edges == 9) begin
                START = 1'b1; DIV_OP = 2'b01; DATA1 = 32'd1; DATA2 = 32'd1;
            end
            @(posedge CLK);
            #1 START = 1'b0;
            edges++;
        end
        checkOutput("busy start latency", first_done, 33);
        checkOutput("busy start result", res, 32'd14);
        checkOutput("busy start done count", dones, 1);
        @(negedge CLK);

        // Asynchronous reset in the middle of an operation
        DIV_OP = 2'b00; DATA1 = 32'd1000; DATA2 = 32'd3; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (14) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        checkOutput("mid reset busy", BUSY, 0);
        checkOutput("mid reset done", DONE, 0);
        checkOutput("mid reset result", RESULT, 0);
        #3 RESET = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        checkOutput("mid reset no done", dones, 0);
        run_check("remu after reset", 2'b11, 32'd1000, 32'd3);
        checkOutput("remu after reset value", RESULT, 32'd1);

        // Back-to-back: second START issued in the DONE cycle of the first
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd1, res, edges, busy_seen);
        checkOutput("b2b first result", res, 32'hFFFF_FFFF);
        checkOutput("b2b first latency", edges, 33);
        applyStimulus(2'b10, 32'h8000_0000, 32'd3, res, edges, busy_seen);
        checkOutput("b2b second result", res, 32'hFFFF_FFFE);
        checkOutput("b2b second latency", edges, 33);
        check_tail("b2b", 32'hFFFF_FFFE);

        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd1;
                3:       b = $urandom_range(2, 20);
                default: b = $urandom;
            endcase
            run_check($sformatf("rand%0d op%0d", i, op), op, a, b);
            check_tail($sformatf("rand%0d", i), ref_result(op, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
